// File: rtl/ps2_letter_decoder.sv
// PS/2 keyboard front end: receives set-2 frames, filters releases, typematic
// repeats and corrupt frames, and emits one pulse per new letter (A=1..Z=26)
// or Enter press.
module ps2_letter_decoder #(
  parameter int unsigned TIMEOUT_CYCLES = 50000,
  parameter int unsigned TO_W           = 16
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  output logic [4:0] char,
  output logic       char_valid,
  output logic       enter,
  output logic [7:0] scan_code,
  output logic       scan_valid,
  output logic       frame_err
);

  localparam logic [7:0] CodeExt   = 8'hE0;
  localparam logic [7:0] CodeBrk   = 8'hF0;
  localparam logic [7:0] CodeEnter = 8'h5A;
  localparam logic [TO_W-1:0] WdLast = TO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StData, StParity, StStop} state_e;

  // Synchronizers and edge detect
  logic clk_meta_q, clk_sync_q, clk_prev_q;
  logic dat_meta_q, dat_sync_q;
  logic fall;

  // Frame receiver
  state_e          state_q;
  logic [2:0]      bit_cnt_q;
  logic [7:0]      shift_q;
  logic            par_ok_q;
  logic [TO_W-1:0] wd_q;
  logic [7:0]      scan_code_q;
  logic            scan_valid_q;
  logic            frame_err_q;

  // Scan-code layer
  logic       ext_q, brk_q;
  logic [7:0] held_q;
  logic [4:0] char_q;
  logic       char_valid_q;
  logic       enter_q;
  logic [4:0] letter;

  function automatic logic [4:0] letter_of(input logic [7:0] code);
    logic [4:0] l;
    case (code)
      8'h1C: l = 5'd1;   8'h32: l = 5'd2;   8'h21: l = 5'd3;   8'h23: l = 5'd4;
      8'h24: l = 5'd5;   8'h2B: l = 5'd6;   8'h34: l = 5'd7;   8'h33: l = 5'd8;
      8'h43: l = 5'd9;   8'h3B: l = 5'd10;  8'h42: l = 5'd11;  8'h4B: l = 5'd12;
      8'h3A: l = 5'd13;  8'h31: l = 5'd14;  8'h44: l = 5'd15;  8'h4D: l = 5'd16;
      8'h15: l = 5'd17;  8'h2D: l = 5'd18;  8'h1B: l = 5'd19;  8'h2C: l = 5'd20;
      8'h3C: l = 5'd21;  8'h2A: l = 5'd22;  8'h1D: l = 5'd23;  8'h22: l = 5'd24;
      8'h35: l = 5'd25;  8'h1A: l = 5'd26;
      default: l = 5'd0;
    endcase
    return l;
  endfunction

  // Two-flop synchronizers; reset to the idle-high bus level so release of
  // reset never looks like a falling edge.
  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      clk_meta_q <= 1'b1;
      clk_sync_q <= 1'b1;
      clk_prev_q <= 1'b1;
      dat_meta_q <= 1'b1;
      dat_sync_q <= 1'b1;
    end else begin
      clk_meta_q <= ps2_clk;
      clk_sync_q <= clk_meta_q;
      clk_prev_q <= clk_sync_q;
      dat_meta_q <= ps2_dat;
      dat_sync_q <= dat_meta_q;
    end
  end

  assign fall = clk_prev_q & ~clk_sync_q;

  // Frame FSM with watchdog; a timeout takes priority only when no edge arrives.
  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      state_q      <= StIdle;
      bit_cnt_q    <= 3'd0;
      shift_q      <= 8'h00;
      par_ok_q     <= 1'b0;
      wd_q         <= '0;
      scan_code_q  <= 8'h00;
      scan_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      scan_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      if (state_q != StIdle && !fall && wd_q == WdLast) begin
        state_q     <= StIdle;
        wd_q        <= '0;
        frame_err_q <= 1'b1;
      end else begin
        if (state_q == StIdle || fall) begin
          wd_q <= '0;
        end else begin
          wd_q <= wd_q + 1'b1;
        end
        if (fall) begin
          case (state_q)
            StIdle: begin
              if (!dat_sync_q) begin
                state_q   <= StData;
                bit_cnt_q <= 3'd0;
              end else begin
                frame_err_q <= 1'b1;
              end
            end
            StData: begin
              shift_q <= {dat_sync_q, shift_q[7:1]};
              if (bit_cnt_q == 3'd7) begin
                state_q <= StParity;
              end else begin
                bit_cnt_q <= bit_cnt_q + 3'd1;
              end
            end
            StParity: begin
              // Odd parity: data plus parity bit must hold an odd number of ones.
              par_ok_q <= ^{dat_sync_q, shift_q};
              state_q  <= StStop;
            end
            StStop: begin
              if (dat_sync_q && par_ok_q) begin
                scan_code_q  <= shift_q;
                scan_valid_q <= 1'b1;
              end else begin
                frame_err_q <= 1'b1;
              end
              state_q <= StIdle;
            end
            default: state_q <= StIdle;
          endcase
        end
      end
    end
  end

  // Letter lookup of the last received byte
  always_comb begin
    letter = letter_of(scan_code_q);
  end

  // Scan-code layer: prefix tracking, release / repeat filtering, output pulses.
  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      ext_q        <= 1'b0;
      brk_q        <= 1'b0;
      held_q       <= 8'h00;
      char_q       <= 5'd0;
      char_valid_q <= 1'b0;
      enter_q      <= 1'b0;
    end else begin
      char_valid_q <= 1'b0;
      enter_q      <= 1'b0;
      if (scan_valid_q) begin
        if (scan_code_q == CodeExt) begin
          ext_q <= 1'b1;
        end else if (scan_code_q == CodeBrk) begin
          brk_q <= 1'b1;
        end else begin
          ext_q <= 1'b0;
          brk_q <= 1'b0;
          if (brk_q) begin
            if (scan_code_q == held_q) begin
              held_q <= 8'h00;
            end
          end else if (scan_code_q == CodeEnter) begin
            enter_q <= 1'b1;
          end else if (!ext_q && letter != 5'd0 && scan_code_q != held_q) begin
            char_q       <= letter;
            char_valid_q <= 1'b1;
            held_q       <= scan_code_q;
          end
        end
      end
    end
  end

  assign char       = char_q;
  assign char_valid = char_valid_q;
  assign enter      = enter_q;
  assign scan_code  = scan_code_q;
  assign scan_valid = scan_valid_q;
  assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_ps2_letter_decoder.sv
// Directed bench for ps2_letter_decoder: table of frames with expected pulse
// counts, plus hand-written latency, timeout and mid-frame reset sequences.
module tb_ps2_letter_decoder;

  localparam int unsigned TO   = 300;
  localparam int          HALF = 10;

  logic       clk = 1'b0;
  logic       resetn = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_dat = 1'b1;
  logic [4:0] char;
  logic       char_valid, enter, scan_valid, frame_err;
  logic [7:0] scan_code;

  ps2_letter_decoder #(.TIMEOUT_CYCLES(TO), .TO_W(16)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .ps2_clk    (ps2_clk),
    .ps2_dat    (ps2_dat),
    .char       (char),
    .char_valid (char_valid),
    .enter      (enter),
    .scan_code  (scan_code),
    .scan_valid (scan_valid),
    .frame_err  (frame_err)
  );

  always #10 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Pulse monitor
  int n_sv = 0, n_cv = 0, n_en = 0, n_fe = 0;
  int sv_cyc = 0, cv_cyc = 0, stop_cyc = 0;
  int n_wide = 0, n_overlap = 0;
  logic p_sv = 0, p_cv = 0, p_en = 0, p_fe = 0;
  always @(negedge clk) begin
    if (scan_valid) begin n_sv++; sv_cyc = cyc; end
    if (char_valid) begin n_cv++; cv_cyc = cyc; end
    if (enter) n_en++;
    if (frame_err) n_fe++;
    if ((scan_valid && p_sv) || (char_valid && p_cv) || (enter && p_en) || (frame_err && p_fe))
      n_wide++;
    if (char_valid && enter) n_overlap++;
    p_sv = scan_valid; p_cv = char_valid; p_en = enter; p_fe = frame_err;
  end

  int n_chk = 0, n_err = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // kind: 0 good, 1 parity flipped, 2 stop bit low. Sends the first nbits bits.
  task automatic send_frame(input logic [7:0] code, input int kind, input int nbits);
    logic [10:0] bits;
    bits[0]   = 1'b0;
    bits[8:1] = code;
    bits[9]   = ~(^code) ^ (kind == 1);
    bits[10]  = (kind != 2);
    for (int i = 0; i < nbits; i++) begin
      ps2_dat = bits[i];
      wait_cyc(HALF);
      ps2_clk = 1'b0;
      if (i == 10) stop_cyc = cyc;
      wait_cyc(HALF);
      ps2_clk = 1'b1;
    end
    ps2_dat = 1'b1;
  endtask

  typedef struct {
    logic [7:0] code;
    int         kind;
    int         sv, cv, en, fe;
    int         ch;
  } vec_t;

  task automatic apply(input vec_t v);
    int sv0, cv0, en0, fe0;
    string tag;
    sv0 = n_sv; cv0 = n_cv; en0 = n_en; fe0 = n_fe;
    send_frame(v.code, v.kind, 11);
    wait_cyc(6);
    tag = $sformatf("%02h/k%0d", v.code, v.kind);
    chk({tag, " scan_valid"}, n_sv - sv0, v.sv);
    chk({tag, " char_valid"}, n_cv - cv0, v.cv);
    chk({tag, " enter"}, n_en - en0, v.en);
    chk({tag, " frame_err"}, n_fe - fe0, v.fe);
    chk({tag, " char"}, int'(char), v.ch);
    if (v.sv != 0) chk({tag, " scan_code"}, int'(scan_code), int'(v.code));
  endtask

  vec_t vecs[14];

  initial begin
    int fe0, sv0;
    vecs[0]  = '{8'h1C, 0, 1, 0, 0, 0, 1};   // typematic repeat
    vecs[1]  = '{8'h1C, 0, 1, 0, 0, 0, 1};
    vecs[2]  = '{8'hF0, 0, 1, 0, 0, 0, 1};
    vecs[3]  = '{8'h1C, 0, 1, 0, 0, 0, 1};   // release
    vecs[4]  = '{8'h1C, 0, 1, 1, 0, 0, 1};   // pressed again
    vecs[5]  = '{8'h2D, 1, 0, 0, 0, 1, 1};   // bad parity
    vecs[6]  = '{8'h2D, 0, 1, 1, 0, 0, 18};
    vecs[7]  = '{8'h2D, 2, 0, 0, 0, 1, 18};  // bad stop bit
    vecs[8]  = '{8'hE0, 0, 1, 0, 0, 0, 18};
    vecs[9]  = '{8'h5A, 0, 1, 0, 1, 0, 18};  // keypad Enter
    vecs[10] = '{8'h5A, 0, 1, 0, 1, 0, 18};
    vecs[11] = '{8'hE0, 0, 1, 0, 0, 0, 18};
    vecs[12] = '{8'h1C, 0, 1, 0, 0, 0, 18};  // extended code ignored
    vecs[13] = '{8'h16, 0, 1, 0, 0, 0, 18};  // digit ignored

    wait_cyc(4);
    chk("reset char", int'(char), 0);
    chk("reset char_valid", int'(char_valid), 0);
    chk("reset enter", int'(enter), 0);
    chk("reset scan_code", int'(scan_code), 0);
    chk("reset scan_valid", int'(scan_valid), 0);
    chk("reset frame_err", int'(frame_err), 0);
    resetn = 1'b0;
    wait_cyc(5);

    // First press with latency check
    apply('{8'h1C, 0, 1, 1, 0, 0, 1});
    chk("scan_valid latency", sv_cyc - stop_cyc, 3);
    chk("char_valid latency", cv_cyc - stop_cyc, 4);

    for (int i = 0; i < 14; i++) apply(vecs[i]);

    // Truncated frame: start + 5 data bits, then silence past the watchdog
    fe0 = n_fe; sv0 = n_sv;
    send_frame(8'h1A, 0, 6);
    wait_cyc(TO + 30);
    chk("timeout frame_err", n_fe - fe0, 1);
    chk("timeout scan_valid", n_sv - sv0, 0);
    apply('{8'h1A, 0, 1, 1, 0, 0, 26});

    // Reset while bit 4 is on the bus
    send_frame(8'h35, 0, 5);
    ps2_dat = 1'b1;
    wait_cyc(HALF);
    ps2_clk = 1'b0;
    wait_cyc(3);
    resetn = 1'b1;
    #1;
    chk("midreset char", int'(char), 0);
    chk("midreset char_valid", int'(char_valid), 0);
    chk("midreset enter", int'(enter), 0);
    chk("midreset scan_code", int'(scan_code), 0);
    chk("midreset scan_valid", int'(scan_valid), 0);
    chk("midreset frame_err", int'(frame_err), 0);
    ps2_clk = 1'b1;
    wait_cyc(4);
    resetn = 1'b0;
    wait_cyc(5);
    apply('{8'h35, 0, 1, 1, 0, 0, 25});

    chk("pulse width", n_wide, 0);
    chk("char_valid/enter overlap", n_overlap, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/ps2_letter_decoder.md
Name: ps2_letter_decoder

Overview:
- Front-end stage feeding the game datapath's 5-bit `char`/`guess` inputs.
- Receives raw PS/2 keyboard frames and decodes the set-2 scan codes.
- Emits one single-cycle pulse per new letter key press, coded A=1 … Z=26 (0 = none). Also emits an Enter pulse, which the control FSM uses to finish word entry.
- Filters out key releases, typematic repeats and corrupt frames.

Parameters:
- TIMEOUT_CYCLES, 50000: idle clk cycles allowed between PS/2 falling edges mid-frame before the frame is aborted (1 ms at 50 MHz).
- TO_W, 16: width of the watchdog counter; must satisfy 2^TO_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  system clock, 50 MHz.
- resetn  in  1  asynchronous, active-high reset (1 = reset).
- ps2_clk  in  1  raw keyboard clock, asynchronous to clk.
- ps2_dat  in  1  raw keyboard data, asynchronous to clk.
- char  out  5  last accepted letter code, 1..26; 0 after reset.
- char_valid  out  1  one-cycle pulse when `char` is updated with a new press.
- enter  out  1  one-cycle pulse on Enter make (0x5A, with or without E0 prefix).
- scan_code  out  8  last complete received byte (debug/HEX display).
- scan_valid  out  1  one-cycle pulse per good frame.
- frame_err  out  1  one-cycle pulse on parity, start or stop error, or timeout.

Behaviour:
- Reset: all outputs 0; FSM in IDLE; prefix flags, held-key register and watchdog cleared. Reset asserted mid-frame discards the partial frame.
- Input conditioning:
  - ps2_clk and ps2_dat each pass through a 2-FF synchronizer.
  - A falling edge is detected as sync_clk: previous=1, current=0.
  - Data is sampled on the same cycle the edge is detected.
- Frame FSM: IDLE -> DATA -> PARITY -> STOP -> IDLE.
  - IDLE: on an edge, if data=0 (start bit) go to DATA with bit_cnt=0. If data=1, stay in IDLE and pulse frame_err.
  - DATA: shift data into an 8-bit register LSB first. After the 8th bit (bit_cnt=7) go to PARITY.
  - PARITY: require odd parity over the 8 data bits plus the parity bit. Record pass/fail and go to STOP.
  - STOP: require data=1 and parity pass. On success, scan_code <= byte and scan_valid=1 on the next cycle; otherwise frame_err=1 and the byte is discarded. Return to IDLE in either case.
- Watchdog:
  - Counts clk cycles while not in IDLE; cleared on every falling edge.
  - Reaching TIMEOUT_CYCLES forces IDLE and pulses frame_err. No scan_valid is produced.
- Scan-code layer (acts only on scan_valid):
  - 0xE0 sets ext flag.
  - 0xF0 sets brk flag.
  - Any other byte is a key code and clears both flags after it is processed.
  - brk=1: release event. If the code equals the held key, clear held. No output.
  - brk=0, code=0x5A: enter pulse, regardless of ext.
  - brk=0, ext=1, other codes: ignored.
  - brk=0, ext=0, letter code: if code ≠ held, then char <= letter, char_valid=1, held <= code. If code = held (typematic repeat), no output.
  - Non-letter, non-Enter codes: ignored; held is unchanged.
- Letter map (scan code -> char):
  - 1C->1, 32->2, 21->3, 23->4, 24->5, 2B->6, 34->7, 33->8, 43->9
  - 3B->10, 42->11, 4B->12, 3A->13, 31->14, 44->15, 4D->16, 15->17
  - 2D->18, 1B->19, 2C->20, 3C->21, 2A->22, 1D->23, 22->24, 35->25, 1A->26
- Latency: char_valid and enter assert exactly 2 clk cycles after the cycle the stop-bit edge is detected (STOP check, then decode). scan_valid asserts 1 cycle after.
- Pulse rules:
  - char_valid, enter, scan_valid and frame_err are never asserted for more than one cycle.
  - char_valid and enter are never asserted in the same cycle.
  - `char` holds its value between pulses.
- A new start bit arriving while the decode stage is still processing is accepted normally; the two stages are independent.

Test Plan:
- Frame 0x1C (A make), PS/2 clock 12.5 kHz -> scan_valid once with scan_code=0x1C; char=1 and char_valid high for exactly 1 cycle, 2 cycles after the stop edge.
- Frames 1C,1C,1C,F0,1C,1C -> exactly two char_valid pulses, both char=1: the first 1C, and the 1C after the release.
- Frame 0x2D with the parity bit flipped -> frame_err 1 cycle, no scan_valid or char_valid. A following good 0x2D -> char=18.
- Start bit plus 5 data bits, then ps2_clk held high for 50001 cycles -> frame_err pulse and FSM back in IDLE. A following good 0x1A -> char=26.
- Frames E0,5A and then 5A -> two enter pulses. Frames E0,1C -> no char_valid. Frames 0x16 (digit 1) -> no output, char unchanged.
- Assert resetn during bit 4 of a frame -> all outputs 0 immediately. After release, frame 0x35 -> char=25, char_valid 1 cycle.
